// File: rtl/clint_responder.sv
`default_nettype none
// ============================================================================
// Module   : clint_responder (with clint_pkg bus types)
// Brief    : Core-local interruptor on the data bus. Holds msip, mtime and
//            mtimecmp, answers LSU requests with a one-cycle ACK and drives
//            the core's timer and software interrupt inputs.
// Revision : 1.0 - initial release
// ============================================================================

package clint_pkg;

  // Request issued by the core's LSU.
  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_query_req_t;

  // Response returned by a responder; err is never raised by this block.
  typedef struct packed {
    logic        ready;
    logic        err;
    logic [31:0] rdata;
  } bus_query_resp_t;

endpackage

module clint_responder
  import clint_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic            clk,
  input  logic            rst,
  input  bus_query_req_t  bus_req,
  output bus_query_resp_t bus_resp,
  output logic            timer_interrupt,
  output logic            software_interrupt
);

  // Word offsets (addr[15:2]) of the mapped registers.
  localparam logic [13:0] c_WORD_MSIP   = 14'h0000;  // 0x0000
  localparam logic [13:0] c_WORD_CMP_LO = 14'h1000;  // 0x4000
  localparam logic [13:0] c_WORD_CMP_HI = 14'h1001;  // 0x4004
  localparam logic [13:0] c_WORD_MT_LO  = 14'h2FFE;  // 0xBFF8
  localparam logic [13:0] c_WORD_MT_HI  = 14'h2FFF;  // 0xBFFC

  // Last prescaler value before it wraps and mtime advances.
  localparam logic [15:0] c_PRESC_MAX   = 16'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [15:0] r_presc;
  logic [15:0] w_presc_nxt;
  logic [63:0] r_mtime;
  logic [63:0] w_mtime_nxt;
  logic [63:0] r_mtimecmp;
  logic [63:0] w_mtimecmp_nxt;
  logic        r_msip;
  logic        w_msip_nxt;
  logic [31:0] r_rdata;
  logic [31:0] w_rdata_sel;
  logic        r_tint;
  logic        r_sint;

  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic        w_tick;
  logic [13:0] w_word;
  logic        w_sel_msip;
  logic        w_sel_cmp_lo;
  logic        w_sel_cmp_hi;
  logic        w_sel_mt_lo;
  logic        w_sel_mt_hi;

  // Only addr[15:2] is decoded; the upstream decoder owns the upper bits
  // and the byte offset inside a word is irrelevant.
  logic        w_unused_addr;
  assign w_unused_addr = ^{bus_req.addr[31:16], bus_req.addr[1:0]};

  // Byte-lane merge of a write into a 32-bit register half.
  function automatic logic [31:0] f_merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  // Request acceptance and address decode; a write with no byte enables
  // is acknowledged but treated as if nothing was written.
  assign w_accept     = (r_state == S_IDLE) && bus_req.valid;
  assign w_wr         = w_accept && bus_req.we && (|bus_req.be);
  assign w_rd         = w_accept && !bus_req.we;
  assign w_word       = bus_req.addr[15:2];
  assign w_sel_msip   = (w_word == c_WORD_MSIP);
  assign w_sel_cmp_lo = (w_word == c_WORD_CMP_LO);
  assign w_sel_cmp_hi = (w_word == c_WORD_CMP_HI);
  assign w_sel_mt_lo  = (w_word == c_WORD_MT_LO);
  assign w_sel_mt_hi  = (w_word == c_WORD_MT_HI);

  // Prescaler: counts 0..TICK_DIV-1, the wrap edge is the mtime tick.
  assign w_tick      = (r_presc == c_PRESC_MAX);
  assign w_presc_nxt = w_tick ? 16'd0 : (r_presc + 16'd1);

  // Next mtime: a bus write to either half beats the tick on the same edge,
  // so the other half never sees a carry caused by a write.
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_wr && w_sel_mt_lo) begin
      w_mtime_nxt[31:0] = f_merge(r_mtime[31:0], bus_req.wdata, bus_req.be);
    end else if (w_wr && w_sel_mt_hi) begin
      w_mtime_nxt[63:32] = f_merge(r_mtime[63:32], bus_req.wdata, bus_req.be);
    end else if (w_tick) begin
      w_mtime_nxt = r_mtime + 64'd1;
    end
  end

  // Next mtimecmp and msip from bus writes.
  always_comb begin
    w_mtimecmp_nxt = r_mtimecmp;
    w_msip_nxt     = r_msip;
    if (w_wr && w_sel_cmp_lo) begin
      w_mtimecmp_nxt[31:0] = f_merge(r_mtimecmp[31:0], bus_req.wdata, bus_req.be);
    end
    if (w_wr && w_sel_cmp_hi) begin
      w_mtimecmp_nxt[63:32] = f_merge(r_mtimecmp[63:32], bus_req.wdata, bus_req.be);
    end
    if (w_wr && w_sel_msip && bus_req.be[0]) begin
      w_msip_nxt = bus_req.wdata[0];
    end
  end

  // Read mux over the pre-update register values; unmapped reads give 0.
  always_comb begin
    w_rdata_sel = 32'h0;
    if (w_sel_msip) begin
      w_rdata_sel = {31'h0, r_msip};
    end else if (w_sel_cmp_lo) begin
      w_rdata_sel = r_mtimecmp[31:0];
    end else if (w_sel_cmp_hi) begin
      w_rdata_sel = r_mtimecmp[63:32];
    end else if (w_sel_mt_lo) begin
      w_rdata_sel = r_mtime[31:0];
    end else if (w_sel_mt_hi) begin
      w_rdata_sel = r_mtime[63:32];
    end
  end

  // Handshake next-state: IDLE accepts, ACK always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus_req.valid) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Architectural registers: prescaler, mtime, mtimecmp, msip.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc    <= 16'd0;
      r_mtime    <= 64'd0;
      r_mtimecmp <= MTIMECMP_RST;
      r_msip     <= 1'b0;
    end else begin
      r_presc    <= w_presc_nxt;
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
      r_msip     <= w_msip_nxt;
    end
  end

  // Read data captured on acceptance and held through ACK; it drops back
  // to 0 on the edge that leaves ACK, and stays 0 for writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= 32'h0;
    end else begin
      r_rdata <= w_rd ? w_rdata_sel : 32'h0;
    end
  end

  // Interrupt outputs registered from the post-update state of each edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tint <= 1'b0;
      r_sint <= 1'b0;
    end else begin
      r_tint <= (w_mtime_nxt >= w_mtimecmp_nxt);
      r_sint <= w_msip_nxt;
    end
  end

  // Response drive: ready comes straight from the state register so that
  // an asynchronous reset removes it immediately.
  always_comb begin
    bus_resp       = '0;
    bus_resp.ready = (r_state == S_ACK);
    bus_resp.rdata = (r_state == S_ACK) ? r_rdata : 32'h0;
  end

  assign timer_interrupt    = r_tint;
  assign software_interrupt = r_sint;

endmodule

`default_nettype wire

// File: tb/tb_clint_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_clint_responder
// Brief    : Scoreboard bench for clint_responder (TICK_DIV=4). Stimulus
//            pushes expected rdata; a negedge monitor pops on every ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clint_responder;
  import clint_pkg::*;

  logic            clk;
  logic            rst;
  bus_query_req_t  req;
  bus_query_resp_t resp;
  logic            tint;
  logic            sint;

  int              n_chk;
  int              n_fail;
  int              cyc;
  logic [31:0]     exp_q[$];
  string           name_q[$];

  clint_responder #(
    .TICK_DIV    (4),
    .MTIMECMP_RST(64'hFFFF_FFFF_FFFF_FFFF)
  ) u_dut (
    .clk               (clk),
    .rst               (rst),
    .bus_req           (req),
    .bus_resp          (resp),
    .timer_interrupt   (tint),
    .software_interrupt(sint)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; after edge k mtime = floor(k/4) absent writes.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on each ready; rdata must be 0 otherwise.
  always @(negedge clk) begin
    logic [31:0] e;
    string       nm;
    if (resp.ready === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ready: got ready=1 rdata=%h expected no response", resp.rdata);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (resp.rdata !== e) begin
          n_fail++;
          $display("FAIL %s: got rdata=%h expected %h", nm, resp.rdata, e);
        end
      end
    end else begin
      n_chk++;
      if (resp.rdata !== 32'h0) begin
        n_fail++;
        $display("FAIL rdata_idle: got %h expected 00000000", resp.rdata);
      end
    end
  end

  // One transaction; entered and left 1ns after a rising edge, so the
  // accept edge is always edge cyc+1.
  task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input logic [31:0] exp, input string nm);
    int n;
    exp_q.push_back(we ? 32'h0 : exp);
    name_q.push_back(nm);
    req.valid = 1'b1;
    req.we    = we;
    req.addr  = {16'h0200, addr};
    req.wdata = wdata;
    req.be    = be;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (resp.ready !== 1'b1 && n < 8);
    if (resp.ready !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no ready expected ready within 8 cycles", nm);
    end
    @(posedge clk); #1;
    req = '0;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // Advance until the next accept edge index modulo 4 equals ph.
  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while (((cyc + 1) % 4) != ph && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    req    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, resp.ready}, 32'h0);
    check("rst_rdata", resp.rdata, 32'h0);
    check("rst_tint", {31'h0, tint}, 32'h0);
    check("rst_sint", {31'h0, sint}, 32'h0);
    rst = 1'b1;

    // Reset values of mtimecmp
    issue(1'b0, 16'h4004, 32'h0, 4'h0, 32'hFFFF_FFFF, "cmp_hi_rst");
    issue(1'b0, 16'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF, "cmp_lo_rst");
    check("tint_after_rst", {31'h0, tint}, 32'h0);

    // mtime counting with TICK_DIV=4; two reads inside one prescaler window
    step_to(40);
    issue(1'b0, 16'hBFF8, 32'h0, 4'h0, cyc / 4, "mtime_lo_40");
    wait_phase(1);
    issue(1'b0, 16'hBFF8, 32'h0, 4'h0, cyc / 4, "mtime_win_a");
    issue(1'b0, 16'hBFF8, 32'h0, 4'h0, cyc / 4, "mtime_win_b");
    issue(1'b0, 16'hBFFC, 32'h0, 4'h0, 32'h0, "mtime_hi");

    // Timer interrupt: mtimecmp = 20
    issue(1'b1, 16'h4004, 32'h0, 4'hF, 32'h0, "wr_cmp_hi");
    issue(1'b1, 16'h4000, 32'd20, 4'hF, 32'h0, "wr_cmp_lo");
    check("tint_below_cmp", {31'h0, tint}, 32'h0);
    step_to(78);
    check("tint_mtime19", {31'h0, tint}, 32'h0);
    step_to(82);
    check("tint_mtime20", {31'h0, tint}, 32'h1);
    issue(1'b1, 16'h4000, 32'd100, 4'hF, 32'h0, "wr_cmp_100");
    check("tint_cleared", {31'h0, tint}, 32'h0);
    issue(1'b0, 16'h4000, 32'h0, 4'h0, 32'd100, "cmp_lo_100");
    issue(1'b1, 16'h4000, 32'hAABB_CCDD, 4'b0101, 32'h0, "wr_cmp_bytes");
    issue(1'b0, 16'h4000, 32'h0, 4'h0, 32'h00BB_00DD, "cmp_lo_bytes");
    issue(1'b0, 16'h4007, 32'h0, 4'h0, 32'h0, "cmp_hi_offs");

    // msip / software interrupt
    issue(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'b0001, 32'h0, "wr_msip_1");
    check("sint_set", {31'h0, sint}, 32'h1);
    issue(1'b0, 16'h0000, 32'h0, 4'h0, 32'h1, "msip_1");
    issue(1'b1, 16'h0000, 32'h0, 4'b0001, 32'h0, "wr_msip_0");
    check("sint_clr", {31'h0, sint}, 32'h0);
    issue(1'b0, 16'h0000, 32'h0, 4'h0, 32'h0, "msip_0");
    issue(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'b0000, 32'h0, "wr_msip_be0");
    check("sint_be0", {31'h0, sint}, 32'h0);
    issue(1'b1, 16'h0000, 32'hFFFF_FFFF, 4'b1110, 32'h0, "wr_msip_hib");
    issue(1'b0, 16'h0000, 32'h0, 4'h0, 32'h0, "msip_still0");

    // Unmapped accesses
    issue(1'b0, 16'h1234, 32'h0, 4'h0, 32'h0, "unmapped_rd");
    issue(1'b1, 16'h1234, 32'hDEAD_BEEF, 4'hF, 32'h0, "unmapped_wr");

    // 64-bit wrap: lo then hi written to all-ones between ticks
    wait_phase(1);
    issue(1'b1, 16'hBFF8, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_mt_lo_ones");
    issue(1'b1, 16'hBFFC, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_mt_hi_ones");
    issue(1'b0, 16'hBFF8, 32'h0, 4'h0, 32'h0, "wrap_lo");
    issue(1'b0, 16'hBFFC, 32'h0, 4'h0, 32'h0, "wrap_hi");

    // Write landing on a tick edge: no +1; read on a tick edge is pre-increment
    wait_phase(0);
    issue(1'b1, 16'hBFF8, 32'h1234_5678, 4'hF, 32'h0, "wr_mt_on_tick");
    issue(1'b0, 16'hBFF8, 32'h0, 4'h0, 32'h1234_5678, "mt_lo_no_inc");
    issue(1'b0, 16'hBFFC, 32'h0, 4'h0, 32'h0, "mt_hi_on_tick");
    issue(1'b0, 16'hBFF8, 32'h0, 4'h0, 32'h1234_5679, "mt_lo_next_tick");

    // Reset during ACK
    issue(1'b1, 16'h0000, 32'h1, 4'b0001, 32'h0, "wr_msip_pre_rst");
    req.valid = 1'b1;
    req.we    = 1'b0;
    req.addr  = 32'h0200_4000;
    req.wdata = 32'h0;
    req.be    = 4'h0;
    @(posedge clk); #1;
    check("ack_before_rst", {31'h0, resp.ready}, 32'h1);
    rst = 1'b0;
    #1;
    check("ready_async_clr", {31'h0, resp.ready}, 32'h0);
    check("rdata_async_clr", resp.rdata, 32'h0);
    req = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("sint_post_rst", {31'h0, sint}, 32'h0);
    check("tint_post_rst", {31'h0, tint}, 32'h0);
    issue(1'b0, 16'hBFF8, 32'h0, 4'h0, cyc / 4, "mt_lo_post_rst");
    issue(1'b0, 16'hBFFC, 32'h0, 4'h0, 32'h0, "mt_hi_post_rst");
    issue(1'b0, 16'h0000, 32'h0, 4'h0, 32'h0, "msip_post_rst");
    issue(1'b0, 16'h4000, 32'h0, 4'h0, 32'hFFFF_FFFF, "cmp_lo_post_rst");
    issue(1'b0, 16'h4004, 32'h0, 4'h0, 32'hFFFF_FFFF, "cmp_hi_post_rst");

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
